// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer owning HI/LO; runs mult/div over a fixed cycle count and stalls F/D.
// Optional MDU_DIVZERO_HOLD_EN: divide by zero keeps HI/LO unchanged instead of writing {A, all-ones}.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_in_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [31:0]   hi_nx, lo_nx, hi_nx_d, lo_nx_d, hi_d, lo_d;

  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, mag_q, mag_r, sdiv_q, sdiv_r, udiv_q, udiv_r;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'b0, A} * {32'b0, B};

  // Signed divide done on magnitudes so INT_MIN/-1 falls out as 0x80000000 rem 0.
  assign a_neg  = A[31];
  assign b_neg  = B[31];
  assign b_zero = (B == 32'd0);
  assign a_mag  = a_neg ? (32'd0 - A) : A;
  assign b_mag  = b_neg ? (32'd0 - B) : B;
  assign mag_q  = b_zero ? 32'd0 : (a_mag / b_mag);
  assign mag_r  = b_zero ? 32'd0 : (a_mag % b_mag);
  assign sdiv_q = (a_neg ^ b_neg) ? (32'd0 - mag_q) : mag_q;
  assign sdiv_r = a_neg ? (32'd0 - mag_r) : mag_r;
  assign udiv_q = b_zero ? 32'd0 : (A / B);
  assign udiv_r = b_zero ? 32'd0 : (A % B);

  assign busy  = (state == BUSY);
  assign stall = md_in_d & (busy | (start & ~op[2]));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi_nx <= 32'd0;
      lo_nx <= 32'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      hi_nx <= hi_nx_d;
      lo_nx <= lo_nx_d;
      HI    <= hi_d;
      LO    <= lo_d;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hi_nx_d  = hi_nx;
    lo_nx_d  = lo_nx;
    hi_d     = HI;
    lo_d     = LO;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1: begin
              {hi_nx_d, lo_nx_d} = (op == 3'd0) ? prod_s : prod_u;
              cnt_nx   = MULT_LD;
              state_nx = BUSY;
            end
            3'd2, 3'd3: begin
              if (b_zero) begin
`ifdef MDU_DIVZERO_HOLD_EN
                hi_nx_d = HI;
                lo_nx_d = LO;
`else
                hi_nx_d = A;
                lo_nx_d = 32'hFFFF_FFFF;
`endif
              end else if (op == 3'd2) begin
                hi_nx_d = sdiv_r;
                lo_nx_d = sdiv_q;
              end else begin
                hi_nx_d = udiv_r;
                lo_nx_d = udiv_q;
              end
              cnt_nx   = DIV_LD;
              state_nx = BUSY;
            end
            3'd4:    hi_d = A;
            3'd5:    lo_d = A;
            default: ;
          endcase
        end
      end
      BUSY: begin
        // start is deliberately ignored here; only the countdown matters.
        if (cnt <= CNT_ONE) begin
          cnt_nx   = '0;
          hi_d     = hi_nx;
          lo_d     = lo_nx;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Table-driven bench for mdu_ctrl plus hand sequences for spurious start and mid-op reset.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

`ifdef MDU_DIVZERO_HOLD_EN
  localparam logic [31:0] DZ0_HI = 32'h1234_5678, DZ0_LO = 32'hCAFE_BABE;
  localparam logic [31:0] DZ1_HI = 32'h1234_5678, DZ1_LO = 32'hCAFE_BABE;
`else
  localparam logic [31:0] DZ0_HI = 32'd5,  DZ0_LO = 32'hFFFF_FFFF;
  localparam logic [31:0] DZ1_HI = 32'd16, DZ1_LO = 32'hFFFF_FFFF;
`endif

  logic        clk = 1'b0;
  logic        reset, start, md_in_d;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          n;
  } vec_t;

  vec_t vecs[15];

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(a), .B(b),
    .md_in_d(md_in_d), .busy(busy), .stall(stall), .HI(hi), .LO(lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one op in the current cycle, then follows it until it retires.
  task automatic applyStimulus(input vec_t v, input int idx);
    start = 1'b1; op = v.op; a = v.a; b = v.b; md_in_d = v.md;
    #1;
    checkOutput($sformatf("v%0d stall_start", idx), {31'b0, stall}, {31'b0, v.md & ~v.op[2]});
    step();
    start = 1'b0;
    #1;
    for (int k = 1; k <= v.n; k++) begin
      checkOutput($sformatf("v%0d busy_c%0d", idx, k), {31'b0, busy}, 32'd1);
      checkOutput($sformatf("v%0d stall_c%0d", idx, k), {31'b0, stall}, {31'b0, v.md});
      step();
    end
    checkOutput($sformatf("v%0d busy_done", idx), {31'b0, busy}, 32'd0);
    checkOutput($sformatf("v%0d stall_done", idx), {31'b0, stall}, 32'd0);
    checkOutput($sformatf("v%0d HI", idx), hi, v.exp_hi);
    checkOutput($sformatf("v%0d LO", idx), lo, v.exp_lo);
  endtask

  initial begin
    vecs[0]  = '{3'd0, 32'hFFFF_FFFE, 32'd3,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MC};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,         1'b0, 32'd1,         32'hFFFF_FFFE, MC};
    vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
    vecs[3]  = '{3'd3, 32'd7,         32'd2,         1'b0, 32'd1,         32'd3,         DC};
    vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0,         32'h8000_0000, DC};
    vecs[5]  = '{3'd4, 32'h1234_5678, 32'd0,         1'b1, 32'h1234_5678, 32'h8000_0000, 0};
    vecs[6]  = '{3'd5, 32'hCAFE_BABE, 32'd0,         1'b0, 32'h1234_5678, 32'hCAFE_BABE, 0};
    vecs[7]  = '{3'd6, 32'd1,         32'd1,         1'b1, 32'h1234_5678, 32'hCAFE_BABE, 0};
    vecs[8]  = '{3'd2, 32'd5,         32'd0,         1'b1, DZ0_HI,        DZ0_LO,        DC};
    vecs[9]  = '{3'd3, 32'd16,        32'd0,         1'b0, DZ1_HI,        DZ1_LO,        DC};
    vecs[10] = '{3'd0, 32'd7,         32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MC};
    vecs[11] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'd0,         MC};
    vecs[12] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 1'b0, 32'd1,         32'hFFFF_FFFD, DC};
    vecs[13] = '{3'd2, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFE, 32'd2,         DC};
    vecs[14] = '{3'd7, 32'd9,         32'd9,         1'b1, 32'hFFFF_FFFE, 32'd2,         0};

    reset = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; md_in_d = 1'b1;
    step();
    step();
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset stall", {31'b0, stall}, 32'd0);
    checkOutput("reset HI", hi, 32'd0);
    checkOutput("reset LO", lo, 32'd0);
    reset = 1'b1;
    step();

    // Vectors run back to back: each new start lands in the cycle busy falls.
    for (int i = 0; i < 15; i++) applyStimulus(vecs[i], i);

    // Spurious mult request in the 3rd busy cycle of divu 100/7 must not disturb it.
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7; md_in_d = 1'b1;
    step();
    start = 1'b0;
    #1;
    for (int k = 1; k <= DC; k++) begin
      if (k == 3) begin
        start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
        #1;
      end
      checkOutput($sformatf("spur busy_c%0d", k), {31'b0, busy}, 32'd1);
      checkOutput($sformatf("spur stall_c%0d", k), {31'b0, stall}, 32'd1);
      step();
      start = 1'b0;
    end
    #1;
    checkOutput("spur busy_done", {31'b0, busy}, 32'd0);
    checkOutput("spur stall_done", {31'b0, stall}, 32'd0);
    checkOutput("spur HI", hi, 32'd2);
    checkOutput("spur LO", lo, 32'd14);
    step();
    checkOutput("spur busy_after", {31'b0, busy}, 32'd0);
    checkOutput("spur HI_after", hi, 32'd2);
    checkOutput("spur LO_after", lo, 32'd14);

    // Reset asserted in the 3rd busy cycle of a mult discards the result.
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4; md_in_d = 1'b0;
    step();
    start = 1'b0;
    step();
    step();
    checkOutput("rst busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("rst busy", {31'b0, busy}, 32'd0);
    checkOutput("rst HI", hi, 32'd0);
    checkOutput("rst LO", lo, 32'd0);
    step();
    reset = 1'b1;
    for (int k = 0; k < 12; k++) step();
    checkOutput("rst busy_later", {31'b0, busy}, 32'd0);
    checkOutput("rst HI_later", hi, 32'd0);
    checkOutput("rst LO_later", lo, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
